// File: rtl/dac_stream_tx.sv
// Left-justified mono-to-stereo serial DAC transmitter with a small sample FIFO.
// Optional macro DAC_TX_HOLD_LAST_EN: on underrun, retransmit the previous word instead of silence.
module dac_stream_tx #(
  parameter int N     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     bclk,
  input  logic                     rst_n,
  input  logic                     daclrc,
  input  logic                     s_valid,
  input  logic [N-1:0]             s_data,
  output logic                     s_ready,
  output logic                     dacdat,
  output logic                     underrun,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int BW = $clog2(N) + 1;

  typedef enum logic [1:0] {SYNC, SHIFT, PAD} state_t;

  state_t          state_reg, state_next;
  logic            lrc_q;
  logic            rise, fall, lrc_edge;
  logic [N-1:0]    mem [DEPTH];
  logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]   level_reg;
  logic [N-1:0]    cur_reg, sh_reg;
  logic [BW-1:0]   bitcnt_reg;
  logic            dacdat_reg, underrun_reg;
  logic            push, pop, fifo_empty, fifo_full;
  logic [N-1:0]    pop_word, empty_word, frame_word, slot_word;
  logic            load_en, shift_en, dacdat_next;

  assign rise     = daclrc & ~lrc_q;
  assign fall     = ~daclrc & lrc_q;
  assign lrc_edge = rise | fall;

  assign fifo_empty = (level_reg == '0);
  assign fifo_full  = (level_reg == LW'(DEPTH));
  assign push       = s_valid & ~fifo_full;
  // A word pushed on the rising-edge cycle is never bypassed into the frame.
  assign pop        = rise & ~fifo_empty;
  assign pop_word   = mem[rd_ptr_reg];

`ifdef DAC_TX_HOLD_LAST_EN
  assign empty_word = cur_reg;
`else
  assign empty_word = '0;
`endif

  assign frame_word = fifo_empty ? empty_word : pop_word;
  // Left slot takes the freshly popped word; the right slot repeats cur.
  assign slot_word  = rise ? frame_word : cur_reg;

  always_ff @(posedge bclk) begin
    if (push) begin
      mem[wr_ptr_reg] <= s_data;
    end
  end

  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= SYNC;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      SYNC:    if (rise) state_next = SHIFT;
      SHIFT:   if (lrc_edge) state_next = SHIFT;
               else if (bitcnt_reg == BW'(N)) state_next = PAD;
      PAD:     if (lrc_edge) state_next = SHIFT;
      default: state_next = SYNC;
    endcase
  end

  always_comb begin
    load_en     = 1'b0;
    shift_en    = 1'b0;
    dacdat_next = 1'b0;
    case (state_reg)
      SYNC: begin
        if (rise) begin
          load_en     = 1'b1;
          dacdat_next = slot_word[N-1];
        end
      end
      SHIFT: begin
        if (lrc_edge) begin
          load_en     = 1'b1;
          dacdat_next = slot_word[N-1];
        end else if (bitcnt_reg != BW'(N)) begin
          shift_en    = 1'b1;
          dacdat_next = sh_reg[N-2];
        end
      end
      PAD: begin
        if (lrc_edge) begin
          load_en     = 1'b1;
          dacdat_next = slot_word[N-1];
        end
      end
      default: begin
        load_en     = 1'b0;
        shift_en    = 1'b0;
        dacdat_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      lrc_q        <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      cur_reg      <= '0;
      sh_reg       <= '0;
      bitcnt_reg   <= '0;
      dacdat_reg   <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      lrc_q        <= daclrc;
      dacdat_reg   <= dacdat_next;
      underrun_reg <= rise & fifo_empty;
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
      if (rise) cur_reg <= frame_word;
      if (load_en) begin
        sh_reg     <= slot_word;
        bitcnt_reg <= BW'(1);
      end else if (shift_en) begin
        sh_reg     <= sh_reg << 1;
        bitcnt_reg <= bitcnt_reg + BW'(1);
      end
    end
  end

  assign s_ready  = ~fifo_full;
  assign dacdat   = dacdat_reg;
  assign underrun = underrun_reg;
  assign level    = level_reg;

endmodule

// File: tb/tb_dac_stream_tx.sv
// Directed scoreboard bench for dac_stream_tx: frames, back-pressure, underrun, short halves, reset.
module tb_dac_stream_tx;

  localparam int N     = 16;
  localparam int DEPTH = 4;
`ifdef DAC_TX_HOLD_LAST_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic                   bclk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   daclrc = 1'b0;
  logic                   s_valid = 1'b0;
  logic [N-1:0]           s_data = '0;
  logic                   s_ready;
  logic                   dacdat;
  logic                   underrun;
  logic [$clog2(DEPTH):0] level;

  int tests = 0;
  int fails = 0;
  logic [N-1:0] sb[$];
  logic [N-1:0] last_word = '0;

  dac_stream_tx #(.N(N), .DEPTH(DEPTH)) dut (
    .bclk(bclk), .rst_n(rst_n), .daclrc(daclrc), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .dacdat(dacdat), .underrun(underrun), .level(level)
  );

  always #5 bclk = ~bclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic push(input logic [N-1:0] d);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!s_ready && n < 50) begin
      @(negedge bclk);
      n++;
    end
    if (n >= 50) chk("push_timeout_ready", 32'(s_ready), 32'd1);
    @(posedge bclk);
    if (s_ready) sb.push_back(d);
    #1 s_valid = 1'b0;
    @(negedge bclk);
    chk("push_level", 32'(level), 32'(sb.size()));
    chk("push_ready", 32'(s_ready), 32'(sb.size() < DEPTH));
    $display("[TB] push %h level=%0d ready=%0d", d, level, s_ready);
  endtask

  // One half-frame of len bclk periods; optional push on the edge-detect cycle.
  task automatic half(input logic val, input int len, input logic do_push, input logic [N-1:0] pd);
    logic [N-1:0] w;
    logic [N-1:0] cap;
    logic         exp_ur;
    logic         pad_or;
    int           nb;
    daclrc = val;
    if (do_push) begin
      s_valid = 1'b1;
      s_data  = pd;
    end
    if (val) begin
      exp_ur = (sb.size() == 0);
      if (exp_ur) w = HOLD ? last_word : '0;
      else        w = sb.pop_front();
      last_word = w;
      if (do_push) sb.push_back(pd);
    end else begin
      exp_ur = 1'b0;
      w      = last_word;
    end
    cap    = '0;
    pad_or = 1'b0;
    nb     = (len < N) ? len : N;
    for (int k = 0; k < len; k++) begin
      @(negedge bclk);
      if (k == 0) begin
        s_valid = 1'b0;
        chk("underrun_pulse", 32'(underrun), 32'(exp_ur));
        chk("frame_level", 32'(level), 32'(sb.size()));
      end
      if (k == 1) chk("underrun_width", 32'(underrun), 32'd0);
      if (k < N) cap = {cap[N-2:0], dacdat};
      else       pad_or = pad_or | dacdat;
    end
    chk(val ? "left_word" : "right_word", 32'(cap), 32'(w >> (N - nb)));
    if (len > N) chk("pad_zero", 32'(pad_or), 32'd0);
    $display("[TB] half lrc=%0d len=%0d word=%h bits=%0d got=%h ur=%0d", val, len, w, nb, cap, exp_ur);
  endtask

  task automatic frame();
    half(1'b1, 32, 1'b0, '0);
    half(1'b0, 32, 1'b0, '0);
  endtask

  initial begin
    logic [N-1:0] w;
    logic         idle_or;

    repeat (3) @(negedge bclk);
    chk("rst_dacdat", 32'(dacdat), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd1);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge bclk);
    chk("sync_idle", 32'(dacdat), 32'd0);

    // Basic frame, then a second word followed by an empty-FIFO frame.
    push(16'hA5C3);
    frame();
    push(16'h7FFF);
    frame();
    frame();

    // Back-pressure: fill, hold a fifth word off, drain two, refill.
    push(16'h1111);
    push(16'h2222);
    push(16'h3333);
    push(16'h4444);
    s_valid = 1'b1;
    s_data  = 16'h5555;
    repeat (5) @(negedge bclk);
    chk("bp_level", 32'(level), 32'd4);
    chk("bp_ready", 32'(s_ready), 32'd0);
    s_valid = 1'b0;
    $display("[TB] backpressure hold level=%0d ready=%0d", level, s_ready);
    frame();
    frame();
    push(16'h5555);
    push(16'h6666);
    frame();
    frame();

    // Simultaneous push and pop at level 2, then push into empty on the edge.
    half(1'b1, 32, 1'b1, 16'h7777);
    half(1'b0, 32, 1'b0, '0);
    frame();
    frame();
    half(1'b1, 32, 1'b1, 16'h8888);
    half(1'b0, 32, 1'b0, '0);
    frame();

    // Short half-frames truncate and restart on every edge.
    push(16'h9ABC);
    half(1'b1, 10, 1'b0, '0);
    half(1'b0, 10, 1'b0, '0);
    half(1'b1, 10, 1'b0, '0);
    half(1'b0, 32, 1'b0, '0);

    // Reset while bit 7 of a word is on the line.
    push(16'hBEEF);
    w = sb.pop_front();
    last_word = w;
    daclrc = 1'b1;
    repeat (9) @(negedge bclk);
    chk("pre_rst_bit7", 32'(dacdat), 32'(w[7]));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_dacdat", 32'(dacdat), 32'd0);
    chk("async_rst_level", 32'(level), 32'd0);
    chk("async_rst_ready", 32'(s_ready), 32'd1);
    $display("[TB] reset asserted mid-word dacdat=%0d level=%0d", dacdat, level);
    @(negedge bclk);
    daclrc = 1'b0;
    repeat (2) @(negedge bclk);
    rst_n = 1'b1;
    sb.delete();
    last_word = '0;
    idle_or = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge bclk);
      idle_or = idle_or | dacdat | underrun;
    end
    chk("post_rst_idle", 32'(idle_or), 32'd0);
    frame();
    push(16'hCAFE);
    frame();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dac_stream_tx.md
# dac_stream_tx

Left-justified serial transmitter feeding the audio CODEC DAC path; the playback-side counterpart of the microphone capture path. Accepts N-bit mono samples over a valid/ready stream, buffers them in a small FIFO, and shifts each sample MSB-first on `dacdat` into both the left and right channel slots framed by the CODEC-driven `daclrc`. The CODEC is bus master: it drives `bclk` and `daclrc`, and is configured for left-justified, N-bit, MSB-first data sampled on the falling edge of BCLK.

## Interface
- `N`, 16: sample width in bits; 2..31.
- `DEPTH`, 4: FIFO depth in samples; power of two, >= 2.
- `bclk` input 1: bit clock from the CODEC. The single clock; all logic on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `daclrc` input 1: DAC frame clock from the CODEC, synchronous to `bclk`. High = left slot, low = right slot.
- `s_valid` input 1: upstream sample valid.
- `s_data` input N: upstream sample, two's complement.
- `s_ready` output 1: FIFO can accept. Equals `!full`.
- `dacdat` output 1: registered serial data to the CODEC.
- `underrun` output 1: one-cycle pulse when a frame starts with the FIFO empty.
- `level` output $clog2(DEPTH)+1: current FIFO occupancy, 0..DEPTH.

## Operation
- Edge detect: `lrc_q` registers `daclrc`. Rising edge = `daclrc & !lrc_q`; falling edge = `!daclrc & lrc_q`.
- FIFO: push when `s_valid & s_ready`. Pop only on a rising edge while `level != 0`. Push and pop in the same cycle are both performed; `level` is unchanged. A push into an empty FIFO on the rising-edge cycle is not bypassed: the frame underruns and the pushed word stays for the next frame.
- Frame word: on each rising edge, `cur` loads the popped word; if the FIFO is empty, `cur` loads 0 (default build) and `underrun` pulses. The right slot reuses `cur`. Both channels carry the same sample.
- States:
  - SYNC (after reset): `dacdat` = 0; falling edges ignored; a rising edge goes to SHIFT.
  - SHIFT: on entry (any LRC edge), the shift register loads the slot word and `dacdat` <= its MSB; `bitcnt` <= 1. Each following cycle, `dacdat` <= the next bit and `bitcnt` increments. After bit 0 has been driven, go to PAD.
  - PAD: `dacdat` <= 0. The next LRC edge re-enters SHIFT.
- An LRC edge arriving in SHIFT before all N bits are sent aborts the current word. SHIFT restarts with the new slot word, with the same pop and underrun rules. This is not an error.
- Arithmetic: `bitcnt` is $clog2(N)+1 bits. FIFO pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. `level` is tracked separately, so full (`level == DEPTH`) and empty (`level == 0`) are unambiguous.

## Timing
- Reset values: `dacdat` = 0, `s_ready` = 1, `underrun` = 0, `level` = 0. `lrc_q`, pointers, `cur` and the shift register are 0. State is SYNC.
- Reset asserted mid-word drives `dacdat` to 0 immediately. The FIFO contents are discarded. Operation resumes at the next rising edge after release.
- Latency: the edge is detected in cycle E, where `daclrc` has changed but `lrc_q` has not. The MSB is on `dacdat` after edge E; bit N-1-k is on `dacdat` after edge E+k. The LSB is on `dacdat` after edge E+N-1, and PAD starts from edge E+N.
- `underrun` is high for exactly cycle E+1 of the affected rising-edge frame.
- `level` and `s_ready` update the cycle after the push or pop. A word pushed at cycle t can first be popped at t+1.
- `bclk` periods per half-frame must be >= N (e.g. 32 for N = 16). Shorter half-frames follow the abort rule.

## Configuration
- `DAC_TX_HOLD_LAST_EN` defined: on underrun, `cur` keeps the previous frame's word and that word is retransmitted. `underrun` still pulses.
- Not defined: on underrun, `cur` = 0 and silence is sent.
- The macro does not affect reset: `cur` still resets to 0.

## Test plan
- Basic frame: push 16'hA5C3; `daclrc` has a 32-bclk half-period. Both slots of the next frame must shift out 1010_0101_1100_0011 MSB-first starting at E+1, followed by 16 zeros. `level` goes 1 -> 0 at the rising edge.
- Back-pressure: push 6 words with `DEPTH` = 4 and no LRC edges. `s_ready` must drop after the 4th accept, and `level` = 4. Words 5 and 6 must be held until a pop, then sent in order.
- Underrun: empty FIFO at a rising edge. `underrun` must pulse once; `dacdat` must stay 0 for the frame in the default build. With `DAC_TX_HOLD_LAST_EN`, the last word 16'h7FFF must be repeated.
- Simultaneous push and pop at `level` = 2 on a rising-edge cycle. `level` must remain 2 and ordering must be preserved. A push into an empty FIFO on that cycle must still underrun.
- Short half-frame: a 10-bclk half-period with N = 16. Each edge must restart the MSB and truncate the word after 10 bits. No lockup.
- Reset: assert `rst_n` at bit 7 of a word. `dacdat` must go 0 asynchronously. After release, a falling edge must be ignored and output must resume at the next rising edge with a fresh FIFO (`underrun` pulses).
